vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Dispense sequencer for the vending machine product motors. It accepts one product-select request at a time over a valid/ready handshake and checks the slot's stock. It drives the selected slot's motor line (one-hot, via the 3:8 slot decoder) for a fixed pulse, then waits for the drop sensor and reports done, empty or jam. It sits between the selection/payment logic and the motor driver outputs.

## Interface
Parameters:
- NSLOT, 8 — number of product slots (one-hot motor width)
- SEL_W, 3 — slot select width, log2(NSLOT)
- STOCK_W, 4 — per-slot stock counter width
- STOCK_INIT, 5 — stock loaded per slot on reset and restock
- PULSE_CYC, 16 — motor-on duration in cycles (≥1)
- TIMEOUT_CYC, 64 — max cycles to wait for drop sensor after pulse (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  1  dispense request valid
- req_sel  in  SEL_W  requested slot index
- req_ready  out  1  controller can accept request
- restock  in  1  reload every slot's stock to STOCK_INIT
- sensor_drop  in  1  product-drop sensor, level, sampled on clk
- motor_en  out  NSLOT  one-hot motor enable, all-zero when idle
- busy  out  1  dispense in progress
- done  out  1  one-cycle pulse: product dispensed
- err_empty  out  1  one-cycle pulse: selected slot empty, nothing driven
- err_jam  out  1  one-cycle pulse: no drop within TIMEOUT_CYC

## Operation
- States: IDLE, DRIVE, WAIT_DROP, REPORT.
- IDLE: req_ready=1. Accept on req_valid&&req_ready; latch req_sel.
  - Slot stock 0: go REPORT with err_empty; no motor.
  - Otherwise go DRIVE and clear the drop flag.
- DRIVE: motor_en = one-hot(latched sel) for exactly PULSE_CYC cycles, then go WAIT_DROP.
- WAIT_DROP: motor_en=0. Count up to TIMEOUT_CYC cycles.
  - Drop flag set, or sensor_drop=1: decrement that slot's stock, go REPORT with done.
  - Counter expires: go REPORT with err_jam; stock unchanged.
- Drop flag: sensor_drop=1 during DRIVE sets it. A set flag completes WAIT_DROP in its first cycle.
- REPORT: assert exactly one of done/err_empty/err_jam for one cycle, then go IDLE.
- busy=1 in DRIVE, WAIT_DROP and REPORT.
- Stock arithmetic:
  - Unsigned STOCK_W.
  - Decrement only when stock>0; never wraps below 0.
  - STOCK_INIT is truncated to STOCK_W.
- restock:
  - Accepted in any state.
  - Same cycle as a decrement: restock wins, and the slot reads STOCK_INIT.
- req_sel ≥ NSLOT (only possible if NSLOT<2^SEL_W): treated as empty, err_empty.
- Inputs are not re-sampled after accept. req_sel changes during a dispense are ignored.

## Timing
- Reset values:
  - State IDLE.
  - motor_en=0, busy=0, done=0, err_empty=0, err_jam=0, req_ready=1.
  - All stock = STOCK_INIT; counters 0; drop flag 0.
- Reset mid-operation: on the next edge, motor_en=0 and no pulse output. Stock is reloaded.
- Accept at edge T:
  - motor_en is high for cycles T+1 through T+PULSE_CYC.
  - WAIT_DROP starts at T+PULSE_CYC+1.
- Drop seen in WAIT_DROP cycle k: REPORT, with done high, in cycle k+1. Stock is updated at the same edge.
- Empty accept at T: err_empty is high in cycle T+1; req_ready returns high at T+2.
- Jam: err_jam is high TIMEOUT_CYC cycles after WAIT_DROP entry.
- Minimum request spacing: PULSE_CYC+3 cycles for a successful dispense.
- All outputs are registered.

## Configuration
- STOCK_TRACK_EN:
  - Defined: per-slot stock counters, restock, err_empty behaviour as above.
  - Undefined: no stock storage. Every valid slot proceeds to DRIVE, and err_empty fires only for an out-of-range req_sel. restock is ignored.

## Structure
- Package vend_pkg:
  - State enum vend_disp_state_t (IDLE, DRIVE, WAIT_DROP, REPORT).
  - Default constants for NSLOT, SEL_W, STOCK_W.
  - Result code enum (OK, EMPTY, JAM) used to select the REPORT pulse.
- Sub-module vend_slot_decoder: SEL_W-to-NSLOT one-hot decoder with enable. motor_en is its output gated by state==DRIVE, then registered.

## Test plan
- Reset, then req_sel=3 with sensor_drop at WAIT_DROP cycle 2 -> motor_en=8'b00001000 for 16 cycles, done pulse, slot 3 stock 5->4.
- Six requests to slot 0 with drops -> five done pulses, sixth gives err_empty and motor_en never asserts.
- req_sel=7 with no sensor_drop -> motor pulse 16 cycles, err_jam 64 cycles later, slot 7 stock remains 5.
- sensor_drop pulsed during DRIVE only -> done in the REPORT cycle immediately after first WAIT_DROP cycle.
- restock asserted in the same cycle as a done-decrement on slot 2 -> slot 2 stock reads 5.
- rst asserted mid-DRIVE -> motor_en=0 and req_ready=1 on the next edge, no done/err pulse; without STOCK_TRACK_EN, empty-slot scenario dispenses normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default sizes for the vending dispense sequencer.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT_DROP,
    REPORT
  } vend_disp_state_t;

  // Outcome of a dispense; selects which pulse fires in REPORT.
  typedef enum logic [1:0] {
    OK,
    EMPTY,
    JAM
  } vend_result_t;

  localparam int VEND_NSLOT   = 8;
  localparam int VEND_SEL_W   = 3;
  localparam int VEND_STOCK_W = 4;

endpackage

// File: rtl/vend_slot_decoder.sv
// SEL_W-to-NSLOT one-hot decoder with enable; all-zero when disabled or sel out of range.
module vend_slot_decoder #(
  parameter int SEL_W = 3,
  parameter int NSLOT = 8
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NSLOT-1:0] onehot
);

  // One line per slot, raised only when enabled and selected
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (en && (int'(sel) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: accepts one slot request, pulses that slot's motor,
// waits for the drop sensor and reports done / empty / jam.
// Optional per-slot stock tracking is enabled by defining STOCK_TRACK_EN.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int NSLOT       = VEND_NSLOT,
  parameter int SEL_W       = VEND_SEL_W,
  parameter int STOCK_W     = VEND_STOCK_W,
  parameter int STOCK_INIT  = 5,
  parameter int PULSE_CYC   = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  input  logic             restock,
  input  logic             sensor_drop,
  output logic [NSLOT-1:0] motor_en,
  output logic             busy,
  output logic             done,
  output logic             err_empty,
  output logic             err_jam
);

  localparam int CNT_MAX = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_INIT);

  vend_disp_state_t   state;
  logic [CNT_W-1:0]   cnt;
  logic               drop_flag;
  logic [SEL_W-1:0]   sel_q;
  logic               slot_ok;
  logic               take;
  logic               dec_en;
  logic [SEL_W-1:0]   dec_sel;
  logic [NSLOT-1:0]   dec_out;

  function automatic logic [STOCK_W-1:0] sat_dec(input logic [STOCK_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [2:0] report_pulse(input vend_result_t r);
    case (r)
      OK:      return 3'b100;
      EMPTY:   return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  assign take = (state == WAIT_DROP) && (drop_flag || sensor_drop);

`ifdef STOCK_TRACK_EN
  logic [STOCK_W-1:0] stock [NSLOT];

  // A request can proceed only for an in-range slot that still holds product
  always_comb begin
    slot_ok = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if ((int'(req_sel) == i) && (stock[i] != '0)) slot_ok = 1'b1;
    end
  end

  // Stock: reset/restock reload every slot (restock beats a same-cycle decrement)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSLOT; i++) begin
      if (rst || restock)               stock[i] <= STOCK_LOAD;
      else if (take && int'(sel_q) == i) stock[i] <= sat_dec(stock[i]);
    end
  end
`else
  logic unused_sig;
  assign unused_sig = restock | take;

  // Without stock tracking only an out-of-range slot is refused
  always_comb slot_ok = int'(req_sel) < NSLOT;
`endif

  // Motor line follows the slot that will be in DRIVE during the next cycle
  always_comb begin
    dec_sel = (state == IDLE) ? req_sel : sel_q;
    dec_en  = ((state == IDLE) && req_valid && slot_ok) ||
              ((state == DRIVE) && (cnt != CNT_W'(PULSE_CYC - 1)));
  end

  vend_slot_decoder #(
    .SEL_W (SEL_W),
    .NSLOT (NSLOT)
  ) u_dec (
    .en     (dec_en),
    .sel    (dec_sel),
    .onehot (dec_out)
  );

  // Sequencer: all outputs registered, result pulses last exactly one REPORT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drop_flag <= 1'b0;
      motor_en  <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      {done, err_empty, err_jam} <= 3'b000;
    end else begin
      motor_en <= dec_out;
      {done, err_empty, err_jam} <= 3'b000;
      case (state)
        IDLE: begin
          if (req_valid) begin
            sel_q     <= req_sel;
            cnt       <= '0;
            drop_flag <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (slot_ok) begin
              state <= DRIVE;
            end else begin
              state <= REPORT;
              {done, err_empty, err_jam} <= report_pulse(EMPTY);
            end
          end
        end
        DRIVE: begin
          if (sensor_drop) drop_flag <= 1'b1;
          if (cnt == CNT_W'(PULSE_CYC - 1)) begin
            state <= WAIT_DROP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DROP: begin
          if (drop_flag || sensor_drop) begin
            state <= REPORT;
            {done, err_empty, err_jam} <= report_pulse(OK);
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state <= REPORT;
            {done, err_empty, err_jam} <= report_pulse(JAM);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl (default parameters, plus a 6-slot instance
// for the out-of-range select case). Honours STOCK_TRACK_EN when defined.
module tb_vend_dispense_ctrl;

  localparam int PULSE   = 16;
  localparam int TMO     = 64;
  localparam int SINIT   = 5;
  localparam int R_OK    = 0;
  localparam int R_EMPTY = 1;
  localparam int R_JAM   = 2;
`ifdef STOCK_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  typedef struct { int code; int unsigned at; } res_t;
  typedef struct { logic [7:0] val; int unsigned start; } mot_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_sel = 3'd0;
  logic       req_ready;
  logic       restock = 1'b0;
  logic       sensor_drop = 1'b0;
  logic [7:0] motor_en;
  logic       busy, done, err_empty, err_jam;

  logic       req_valid2 = 1'b0;
  logic [2:0] req_sel2 = 3'd0;
  logic       req_ready2;
  logic [5:0] motor_en2;
  logic       busy2, done2, err_empty2, err_jam2;

  int unsigned cyc = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int m_stock [8];
  res_t res_q[$];
  mot_t mot_q[$];
  res_t m_res;
  mot_t m_mot;
  logic [7:0] run_val;
  int unsigned run_len = 0, run_start = 0;

  vend_dispense_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .restock(restock), .sensor_drop(sensor_drop),
    .motor_en(motor_en), .busy(busy), .done(done), .err_empty(err_empty),
    .err_jam(err_jam)
  );

  vend_dispense_ctrl #(.NSLOT(6)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_sel(req_sel2),
    .req_ready(req_ready2), .restock(1'b0), .sensor_drop(1'b0),
    .motor_en(motor_en2), .busy(busy2), .done(done2), .err_empty(err_empty2),
    .err_jam(err_jam2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] code_bits(input int c);
    if (c == R_OK) return 3'b100;
    if (c == R_EMPTY) return 3'b010;
    return 3'b001;
  endfunction

  // Output monitor: pops expected results and motor pulses as the DUT produces them
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (done || err_empty || err_jam) begin
        if (res_q.size() == 0) begin
          check("unexpected_result", {29'd0, done, err_empty, err_jam}, 32'd0);
        end else begin
          m_res = res_q.pop_front();
          check("result_kind", {29'd0, done, err_empty, err_jam}, {29'd0, code_bits(m_res.code)});
          check("result_cycle", cyc, m_res.at);
        end
      end
      if (motor_en != 8'd0) begin
        if (run_len == 0) begin
          run_val   = motor_en;
          run_start = cyc;
        end
        run_len++;
      end else if (run_len != 0) begin
        if (mot_q.size() == 0) begin
          check("motor_unexpected", {24'd0, run_val}, 32'd0);
        end else begin
          m_mot = mot_q.pop_front();
          check("motor_val", {24'd0, run_val}, {24'd0, m_mot.val});
          check("motor_start", run_start, m_mot.start);
          check("motor_len", run_len, PULSE);
        end
        run_len = 0;
      end
    end
  end

  // drop_k: WAIT_DROP cycle (0-based) with sensor_drop high, -1 for none
  task automatic dispense(input int sel, input int drop_k, input bit drop_in_drive,
                          input bit restock_at_dec);
    int unsigned a;
    int unsigned at;
    int code;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_sel   = sel[2:0];
    a = cyc + 1;
    if (TRACK && m_stock[sel] == 0) begin
      code = R_EMPTY; at = a;
    end else if (drop_in_drive) begin
      code = R_OK; at = a + PULSE + 1;
    end else if (drop_k >= 0) begin
      code = R_OK; at = a + PULSE + drop_k + 1;
    end else begin
      code = R_JAM; at = a + PULSE + TMO;
    end
    res_q.push_back('{code, at});
    if (code != R_EMPTY) mot_q.push_back('{8'(1 << sel), a});
    if (TRACK && code == R_OK) begin
      if (restock_at_dec) for (int i = 0; i < 8; i++) m_stock[i] = SINIT;
      else m_stock[sel] = m_stock[sel] - 1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_sel   = ~sel[2:0];
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    check("busy_on", {31'd0, busy}, 32'd1);
    while (cyc < at + 2) begin
      @(negedge clk);
      sensor_drop = drop_in_drive ? (cyc == a + 3)
                                  : (drop_k >= 0 && cyc == a + PULSE + drop_k);
      restock = restock_at_dec && (cyc == a + PULSE + drop_k);
      if (code == R_EMPTY && cyc == a + 1)
        check("empty_ready_back", {31'd0, req_ready}, 32'd1);
    end
    sensor_drop = 1'b0;
    restock     = 1'b0;
    check("result_seen", res_q.size(), 32'd0);
    check("motor_seen", mot_q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_stock[i] = SINIT;
    repeat (2) @(negedge clk);
    check("rst_motor", {24'd0, motor_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {29'd0, done, err_empty, err_jam}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;

    dispense(3, 2, 1'b0, 1'b0);
`ifdef STOCK_TRACK_EN
    check("stock3", {28'd0, dut.stock[3]}, 32'd4);
`endif
    for (int n = 0; n < 6; n++) dispense(0, 0, 1'b0, 1'b0);
    dispense(7, -1, 1'b0, 1'b0);
`ifdef STOCK_TRACK_EN
    check("stock7", {28'd0, dut.stock[7]}, 32'd5);
`endif
    dispense(1, -1, 1'b1, 1'b0);
    dispense(2, 1, 1'b0, 1'b1);
`ifdef STOCK_TRACK_EN
    check("stock2_restock", {28'd0, dut.stock[2]}, 32'd5);
`endif
    dispense(6, 0, 1'b0, 1'b0);

    // reset in the middle of a motor pulse
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    check("motor_pre_rst", {24'd0, motor_en}, 32'h10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_motor", {24'd0, motor_en}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pulses", {29'd0, done, err_empty, err_jam}, 32'd0);
`ifdef STOCK_TRACK_EN
    check("midrst_stock6", {28'd0, dut.stock[6]}, 32'd5);
`endif
    for (int i = 0; i < 8; i++) m_stock[i] = SINIT;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    dispense(4, 3, 1'b0, 1'b0);

    // out-of-range select on the 6-slot instance
    @(negedge clk);
    req_valid2 = 1'b1;
    req_sel2   = 3'd7;
    @(negedge clk);
    req_valid2 = 1'b0;
    check("oor_empty", {31'd0, err_empty2}, 32'd1);
    check("oor_motor", {26'd0, motor_en2}, 32'd0);
    check("oor_busy", {31'd0, req_ready2}, 32'd0);
    @(negedge clk);
    check("oor_ready_back", {31'd0, req_ready2}, 32'd1);
    check("oor_pulse_once", {29'd0, done2, err_empty2, err_jam2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
